// File: rtl/triangle_pwm_driver_if.sv
// Level input and PWM/direction status outputs of the triangle PWM driver.
// The driver is the slave; whoever supplies level and observes status is the master.
interface triangle_pwm_driver_if;
  logic [3:0] level;
  logic       pwm_out;
  logic       frame_start;
  logic       dir;
  logic       peak;
  logic       trough;
  logic [7:0] cycles;

  modport master (
    output level,
    input  pwm_out, frame_start, dir, peak, trough, cycles
  );

  modport slave (
    input  level,
    output pwm_out, frame_start, dir, peak, trough, cycles
  );
endinterface

// File: rtl/triangle_pwm_driver.sv
// Turns a 4-bit triangle level into a 16-clock-frame PWM and tracks the wave's
// direction, emitting peak/trough pulses and a wrapping count of troughs.
//
// state   | meaning
// FALLING | level last moved down; next rise is a trough
// RISING  | level last moved up (reset value); next fall is a peak
module triangle_pwm_driver (
  input logic CP,
  input logic CLEAR,
  triangle_pwm_driver_if.slave bus
);

  typedef enum logic {
    FALLING = 1'b0,
    RISING  = 1'b1
  } dir_t;

  logic [3:0] pwm_cnt;
  logic [3:0] duty_q;
  logic [3:0] prev_level;
  dir_t       dir_q;
  logic       peak_q;
  logic       trough_q;
  logic [7:0] cycles_q;

  always_ff @(posedge CP or posedge CLEAR) begin
    if (CLEAR) begin
      pwm_cnt    <= 4'd0;
      duty_q     <= 4'd0;
      prev_level <= 4'd0;
      dir_q      <= RISING;
      peak_q     <= 1'b0;
      trough_q   <= 1'b0;
      cycles_q   <= 8'd0;
    end else begin
      // Duty is captured only at the frame boundary so a frame never glitches.
      pwm_cnt <= pwm_cnt + 4'd1;
      if (pwm_cnt == 4'd15) begin
        duty_q <= bus.level;
      end

      prev_level <= bus.level;
      peak_q     <= 1'b0;
      trough_q   <= 1'b0;
      if (bus.level > prev_level) begin
        if (dir_q == FALLING) begin
          trough_q <= 1'b1;
          cycles_q <= cycles_q + 8'd1;
          dir_q    <= RISING;
        end
      end else if (bus.level < prev_level) begin
        if (dir_q == RISING) begin
          peak_q <= 1'b1;
          dir_q  <= FALLING;
        end
      end
    end
  end

  // Decoded from registers only, so level has no path to the LED pin.
  assign bus.pwm_out     = (pwm_cnt < duty_q);
  assign bus.frame_start = (pwm_cnt == 4'd0);
  assign bus.dir         = (dir_q == RISING);
  assign bus.peak        = peak_q;
  assign bus.trough      = trough_q;
  assign bus.cycles      = cycles_q;

endmodule

// File: tb/tb_triangle_pwm_driver.sv
// Scoreboard bench for triangle_pwm_driver: each stimulus step queues the
// hand-derived post-edge outputs; a negedge monitor pops and compares them.
module tb_triangle_pwm_driver;

  logic CP    = 1'b0;
  logic CLEAR = 1'b1;

  triangle_pwm_driver_if bus ();

  triangle_pwm_driver dut (
    .CP    (CP),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic       chk_pwm;
    logic       chk_dir;
    logic       tally;
    logic       pwm;
    logic       fs;
    logic       dir;
    logic       peak;
    logic       trough;
    logic [7:0] cycles;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n_pass = 0;
  int    n_total = 0;
  int    pwm_tally = 0;
  int    trough_seen = 0;
  int    peak_seen = 0;
  string phase = "reset";

  task automatic check(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h required 0x%0h at %0t", phase, nm, act, req, $time);
  endtask

  function automatic exp_t mk(input logic chk_pwm, input logic pwm, input logic fs,
                              input logic chk_dir, input logic dir, input logic peak,
                              input logic trough, input logic [7:0] cycles);
    exp_t e;
    e.chk_pwm = chk_pwm;
    e.chk_dir = chk_dir;
    e.tally   = 1'b0;
    e.pwm     = pwm;
    e.fs      = fs;
    e.dir     = dir;
    e.peak    = peak;
    e.trough  = trough;
    e.cycles  = cycles;
    return e;
  endfunction

  always @(negedge CP) begin
    if (!CLEAR && sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (bus.trough) trough_seen++;
      if (bus.peak) peak_seen++;
      if (mon_e.tally && bus.pwm_out) pwm_tally++;
      if (mon_e.chk_pwm)
        check("pwm_fs", int'({bus.pwm_out, bus.frame_start}), int'({mon_e.pwm, mon_e.fs}));
      if (mon_e.chk_dir)
        check("dir_pk_tr_cyc", int'({bus.dir, bus.peak, bus.trough, bus.cycles}),
              int'({mon_e.dir, mon_e.peak, mon_e.trough, mon_e.cycles}));
    end
  end

  task automatic step(input logic [3:0] lv, input exp_t e);
    bus.level = lv;
    @(posedge CP);
    sb.push_back(e);
    #1;
  endtask

  task automatic drain();
    @(negedge CP);
    #1;
  endtask

  function automatic int all_outputs();
    return int'({bus.pwm_out, bus.frame_start, bus.dir, bus.peak, bus.trough, bus.cycles});
  endfunction

  // Asserts CLEAR between edges and checks reset values with no clock edge.
  task automatic do_reset();
    @(posedge CP);
    #1;
    CLEAR = 1'b1;
    bus.level = 4'd0;
    #2;
    check("reset_values", all_outputs(), int'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    @(negedge CP);
    #1;
    CLEAR = 1'b0;
    trough_seen = 0;
    peak_seen = 0;
    pwm_tally = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0] lv;
    bus.level = 4'd0;

    // Level 0: PWM never high, frame_start every 16 edges, no direction events.
    phase = "hold0";
    do_reset();
    for (int k = 1; k <= 64; k++)
      step(4'd0, mk(1, 0, (k % 16) == 0, 1, 1, 0, 0, 8'd0));
    drain();

    // Level 5: first frame dark, then 5/16 duty.
    phase = "hold5";
    do_reset();
    for (int k = 1; k <= 48; k++)
      step(4'd5, mk(1, (k >= 16) && ((k % 16) < 5), (k % 16) == 0, 1, 1, 0, 0, 8'd0));
    drain();

    // Level 9 sampled at the boundary, then level thrashes 0/15 during the frame.
    phase = "sweep";
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      if (k < 16) lv = 4'd0;
      else if (k == 16) lv = 4'd9;
      else lv = (k % 2) ? 4'd15 : 4'd0;
      e = mk(1, (k >= 16) && ((k - 16) < 9), (k % 16) == 0, 0, 0, 0, 0, 8'd0);
      e.tally = (k >= 16);
      step(lv, e);
    end
    drain();
    check("pwm_high_count", pwm_tally, 9);

    // One full triangle 0..15..0..1.
    phase = "triangle";
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      if (k == 1) lv = 4'd0;
      else if (k <= 16) lv = 4'(k - 1);
      else if (k <= 31) lv = 4'(31 - k);
      else lv = 4'd1;
      step(lv, mk(1,
                  (k < 16) ? 1'b0 : (k < 32) ? ((k - 16) < 15) : 1'b1,
                  (k % 16) == 0,
                  1,
                  (k < 17) || (k == 32),
                  k == 17,
                  k == 32,
                  (k == 32) ? 8'd1 : 8'd0));
    end
    drain();
    check("peak_count", peak_seen, 1);
    check("trough_count", trough_seen, 1);
    check("cycles_after_one", int'(bus.cycles), 1);

    // 256 triangle cycles: the cycle counter must wrap back to 0.
    phase = "wrap256";
    do_reset();
    for (int i = 1; i <= 16; i++)
      step(4'(i - 1), mk(0, 0, 0, 1, 1, 0, 0, 8'd0));
    for (int j = 1; j <= 256; j++)
      for (int o = 0; o < 30; o++) begin
        lv = (o < 15) ? 4'(14 - o) : 4'(o - 14);
        step(lv, mk(0, 0, 0, 1, o >= 15, o == 0, o == 15,
                    (o >= 15) ? 8'(j) : 8'(j - 1)));
      end
    drain();
    check("trough_count_256", trough_seen, 256);
    check("cycles_wrapped", int'(bus.cycles), 0);

    // Mid-descent CLEAR at level 7, dir 0, cycles 3, pwm_cnt 9.
    phase = "midclear";
    do_reset();
    for (int i = 0; i < 7; i++) step(4'd0, mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
    for (int i = 0; i < 16; i++) step(4'(i), mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
    for (int j = 1; j <= 3; j++)
      for (int o = 0; o < 30; o++)
        step((o < 15) ? 4'(14 - o) : 4'(o - 14), mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
    for (int v = 14; v >= 7; v--) step(4'(v), mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
    drain();
    check("pre_clear_state", all_outputs(), int'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3}));
    @(posedge CP);
    #3;
    CLEAR = 1'b1;
    #1;
    check("async_clear", all_outputs(), int'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    @(negedge CP);
    #1;
    CLEAR = 1'b0;
    for (int k = 1; k <= 16; k++)
      step(4'd7, mk(1, k == 16, k == 16, 1, 1, 0, 0, 8'd0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/triangle_pwm_driver.md
# triangle_pwm_driver

Downstream consumer of the 4-bit up/down triangle counter: it turns the counter's 4-bit level into an LED-dimming PWM waveform and reports the direction of the triangle wave. Each PWM frame latches one level sample, so a level change can never glitch a frame in progress. Direction tracking raises peak and trough pulses and keeps a count of completed triangle cycles for status/debug logic. The block sits on the same clock and clear as the counter and drives the LED pin plus status outputs.

## Interface
Parameters: none (frame length fixed at 16 clocks, cycle counter fixed at 8 bits).

Ports:
- CP  input  1  clock; all state updates on posedge CP
- CLEAR  input  1  asynchronous, active-high reset; forces all state to reset values immediately
- level  input  4  unsigned level from the triangle counter, sampled on posedge CP
- pwm_out  output  1  PWM waveform, duty = duty_q/16
- frame_start  output  1  one-cycle pulse, high during pwm_cnt == 0
- dir  output  1  1 = level rising, 0 = level falling
- peak  output  1  one-cycle pulse on rising→falling turn
- trough  output  1  one-cycle pulse on falling→rising turn
- cycles  output  8  count of trough events, wraps 255→0

## Operation
- Internal registers: pwm_cnt[3:0], duty_q[3:0], prev_level[3:0].
- PWM frame:
  - pwm_cnt increments by 1 each edge; 15→0 wraps.
  - On the edge where pwm_cnt == 15: duty_q <= level, and pwm_cnt <= 0.
- pwm_out = (pwm_cnt < duty_q):
  - Combinational from registers only; no path from level to pwm_out.
  - level 0 gives constant low; level 15 gives 15 high cycles and 1 low cycle.
- frame_start = (pwm_cnt == 0), decoded from registers.
- Direction tracker, evaluated every edge against prev_level, then prev_level <= level:
  - level > prev_level and dir == 0: trough <= 1, cycles <= cycles + 1, dir <= 1.
  - level > prev_level and dir == 1: trough <= 0, dir holds.
  - level < prev_level and dir == 1: peak <= 1, dir <= 0.
  - level < prev_level and dir == 0: peak <= 0, dir holds.
  - level == prev_level: dir holds, peak <= 0, trough <= 0.
  - peak and trough are never high in the same cycle; each lasts exactly one cycle.
- cycles: 8-bit modular addition, no saturation.

## Timing
- Reset values (CLEAR high, independent of CP):
  - pwm_cnt = 0, duty_q = 0, prev_level = 0.
  - pwm_out = 0, frame_start = 1 (pwm_cnt == 0).
  - dir = 1 (matches the counter's post-clear upward count), peak = 0, trough = 0, cycles = 0.
- First frame after reset runs at duty 0. The level sampled on the 16th edge after CLEAR release becomes the duty of the second frame.
- PWM latency: a level sampled at the pwm_cnt == 15 edge appears on pwm_out from the next cycle (pwm_cnt == 0) for all 16 cycles of that frame.
- Direction latency: peak, trough, dir and cycles update on the edge that samples the turning value. They are visible in the following cycle.
- Counter boundary behaviour:
  - The counter's 15→14 turn produces peak one cycle after 14 is first sampled.
  - The counter's 1→0→1 turn produces trough when 1 is sampled after 0.
  - The initial 0→1 after reset produces no trough, because dir is already 1.
- CLEAR asserted mid-frame or mid-cycle:
  - Immediate return to reset values.
  - An in-progress pulse is cut short.
  - The frame restarts at pwm_cnt = 0 on CLEAR release.
- level changing every cycle does not affect the current frame's duty; only the sample taken at pwm_cnt == 15 matters.

## Test plan
- Reset, then hold level = 0 for 64 edges → pwm_out stays 0, frame_start pulses every 16 cycles, dir = 1, no peak/trough, cycles = 0.
- Hold level = 5 from reset → frame 1 all low; from frame 2 onward pwm_out is high for pwm_cnt 0..4 and low for 5..15 (5/16 duty).
- Level sweep within a frame:
  - Stimulus: level = 9 sampled at pwm_cnt == 15, then level toggles 0/15 every cycle for the next frame.
  - Required: pwm_out high for exactly 9 cycles of that frame.
- Drive the counter's full sequence 0..15..0..1 →
  - exactly one peak, one cycle after 14 is sampled;
  - dir = 0 through the descent;
  - one trough when 1 is sampled after 0;
  - cycles = 1.
- Run 256 full triangle cycles → 256 trough pulses, and cycles wraps to 0 after the 256th.
- Assert CLEAR asynchronously mid-descent (level = 7, dir = 0, cycles = 3, pwm_cnt = 9) → all outputs go to reset values without a clock edge; after release, frame timing restarts from pwm_cnt = 0.
